// File: rtl/cpu1_pkg.sv
// Shared defaults and loader state encoding for the cpu1 block.
package cpu1_pkg;
  localparam int unsigned WIDTH_DEF    = 4;
  localparam int unsigned ADDRSIZE_DEF = 8;
  localparam logic [3:0]  SYNC_DEF     = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_L,
    ST_ADDR_H,
    ST_LEN_L,
    ST_LEN_H,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } ld_state_e;
endpackage

// File: rtl/loader_mem.sv
// Program RAM: one write port, one registered read port, read-before-write.
import cpu1_pkg::*;

module loader_mem #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [WIDTH-1:0]    rdata_o
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset so a load survives a CPU reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/prog_loader.sv
// Nibble-stream program loader: SYNC, addr, len, data[, csum] into loader_mem.
// LOADER_CSUM_EN enables the trailing checksum nibble and the err flag.
import cpu1_pkg::*;

module prog_loader #(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter int               ADDRSIZE = ADDRSIZE_DEF,
  parameter logic [WIDTH-1:0] SYNC     = WIDTH'(SYNC_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic                cpu_hold,
  input  logic [ADDRSIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic                load_done,
  output logic                err
);
  ld_state_e           state_q, state_d;
  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                xfer;
  logic                mem_we;

  assign in_ready  = (state_q != ST_DONE);
  assign cpu_hold  = (state_q != ST_IDLE);
  assign load_done = (state_q == ST_DONE);
  assign xfer      = in_valid && in_ready;
  assign mem_we    = xfer && (state_q == ST_DATA) && reset;

`ifdef LOADER_CSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;
  logic             err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
`ifdef LOADER_CSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
`ifdef LOADER_CSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
`ifdef LOADER_CSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: if (xfer && in_data == SYNC) begin
        state_d = ST_ADDR_L;
`ifdef LOADER_CSUM_EN
        csum_d  = '0;
        err_d   = 1'b0;
`endif
      end
      ST_ADDR_L: if (xfer) begin
        lo_d    = in_data;
        state_d = ST_ADDR_H;
      end
      ST_ADDR_H: if (xfer) begin
        wptr_d  = ADDRSIZE'({in_data, lo_q});
        state_d = ST_LEN_L;
      end
      ST_LEN_L: if (xfer) begin
        lo_d    = in_data;
        state_d = ST_LEN_H;
      end
      // Count down from len; len 0 wraps through the full depth.
      ST_LEN_H: if (xfer) begin
        rem_d   = ADDRSIZE'({in_data, lo_q});
        state_d = ST_DATA;
      end
      ST_DATA: if (xfer) begin
        wptr_d = wptr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
`ifdef LOADER_CSUM_EN
        csum_d = csum_q ^ in_data;
        if (rem_q == ADDRSIZE'(1)) state_d = ST_CSUM;
`else
        if (rem_q == ADDRSIZE'(1)) state_d = ST_DONE;
`endif
      end
      ST_CSUM: if (xfer) begin
`ifdef LOADER_CSUM_EN
        if (in_data != csum_q) err_d = 1'b1;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  loader_mem #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );
endmodule
